// File: rtl/mandel_frame_reader.sv
// Raster-order framebuffer reader: walks the partitioned M10K array and streams colour bytes.
// Optional frame counter output enabled by defining MANDEL_FRAME_COUNT_EN.
module mandel_frame_reader #(
    parameter int PARTITION      = 2,
    parameter int PARTITION_COLS = 320,
    parameter int PARTITION_ROWS = 480,
    parameter int READ_LATENCY   = 2,
    localparam int W  = PARTITION * PARTITION_COLS,
    localparam int AW = $clog2(PARTITION_COLS * PARTITION_ROWS),
    localparam int PW = $clog2(PARTITION),
    localparam int XW = $clog2(W),
    localparam int YW = $clog2(PARTITION_ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          iter_done,
    output logic [AW-1:0] m10k_read_address,
    output logic [PW-1:0] partition_index,
    input  logic [7:0]    vga_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [7:0]    pix_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_last,
    output logic          busy,
    output logic          frame_done
`ifdef MANDEL_FRAME_COUNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int DEPTH = READ_LATENCY + 2;
    localparam int CW    = (PARTITION_COLS > 1) ? $clog2(PARTITION_COLS) : 1;
    localparam int FW    = $clog2(DEPTH);
    localparam int NW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_FETCH, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [PW-1:0]   part_q, part_d;
    logic [YW-1:0]   row_q, row_d;
    logic [AW-1:0]   base_q, base_d;
    logic [XW-1:0]   x_q, x_d;

    logic [READ_LATENCY-1:0] vld_q;
    logic [XW-1:0]   tag_x_q    [READ_LATENCY];
    logic [YW-1:0]   tag_y_q    [READ_LATENCY];
    logic            tag_last_q [READ_LATENCY];

    logic [7:0]      mem_data [DEPTH];
    logic [XW-1:0]   mem_x    [DEPTH];
    logic [YW-1:0]   mem_y    [DEPTH];
    logic            mem_last [DEPTH];
    logic [FW-1:0]   wr_q, rd_q;
    logic [NW-1:0]   count_q, inflight_q;
    logic            frame_done_q;

    logic col_end, part_end, row_end, last_rd, credit_ok;
    logic issue, push, pop, head_last, drain_end;

    assign col_end   = (col_q == CW'(PARTITION_COLS - 1));
    assign part_end  = (part_q == PW'(PARTITION - 1));
    assign row_end   = (row_q == YW'(PARTITION_ROWS - 1));
    assign last_rd   = col_end && part_end && row_end;
    // Credit: every issued read must already own a FIFO slot when its data returns.
    assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (NW + 1)'(DEPTH);
    assign push      = vld_q[READ_LATENCY-1];
    assign pop       = pix_valid && pix_ready;
    assign head_last = mem_last[rd_q];
    assign drain_end = (state_q == S_DRAIN) && pop && head_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start)             state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (iter_done)         state_d = S_FETCH;
            S_FETCH:     if (issue && last_rd)  state_d = S_DRAIN;
            S_DRAIN:     if (drain_end)         state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        issue = (state_q == S_FETCH) && credit_ok;
    end

    // Raster walk: column, then strip, then row; row_base replaces a row*COLS multiply.
    always_comb begin
        col_d  = col_q;
        part_d = part_q;
        row_d  = row_q;
        base_d = base_q;
        x_d    = x_q;
        if (issue) begin
            if (col_end) begin
                col_d = '0;
                if (part_end) begin
                    part_d = '0;
                    x_d    = '0;
                    if (row_end) begin
                        row_d  = '0;
                        base_d = '0;
                    end else begin
                        row_d  = row_q + YW'(1);
                        base_d = base_q + AW'(PARTITION_COLS);
                    end
                end else begin
                    part_d = part_q + PW'(1);
                    x_d    = x_q + XW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                x_d   = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q  <= '0;
            part_q <= '0;
            row_q  <= '0;
            base_q <= '0;
            x_q    <= '0;
        end else begin
            col_q  <= col_d;
            part_q <= part_d;
            row_q  <= row_d;
            base_q <= base_d;
            x_q    <= x_d;
        end
    end

    assign m10k_read_address = base_q + AW'(col_q);
    assign partition_index   = part_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_x_q[0]    <= x_q;
        tag_y_q[0]    <= row_q;
        tag_last_q[0] <= last_rd;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_x_q[i]    <= tag_x_q[i-1];
            tag_y_q[i]    <= tag_y_q[i-1];
            tag_last_q[i] <= tag_last_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_q] <= vga_data;
            mem_x[wr_q]    <= tag_x_q[READ_LATENCY-1];
            mem_y[wr_q]    <= tag_y_q[READ_LATENCY-1];
            mem_last[wr_q] <= tag_last_q[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (push) wr_q <= (wr_q == FW'(DEPTH - 1)) ? '0 : wr_q + FW'(1);
            if (pop)  rd_q <= (rd_q == FW'(DEPTH - 1)) ? '0 : rd_q + FW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + NW'(1);
                2'b01:   count_q <= count_q - NW'(1);
                default: count_q <= count_q;
            endcase
            case ({issue, push})
                2'b10:   inflight_q <= inflight_q + NW'(1);
                2'b01:   inflight_q <= inflight_q - NW'(1);
                default: inflight_q <= inflight_q;
            endcase
            frame_done_q <= drain_end;
        end
    end

    // Head fields are gated so outputs read zero whenever the FIFO is empty.
    assign pix_valid  = (count_q != '0);
    assign pix_data   = pix_valid ? mem_data[rd_q] : '0;
    assign pix_x      = pix_valid ? mem_x[rd_q]    : '0;
    assign pix_y      = pix_valid ? mem_y[rd_q]    : '0;
    assign pix_last   = pix_valid && head_last;
    assign frame_done = frame_done_q;

`ifdef MANDEL_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          frame_count_q <= '0;
        else if (drain_end) frame_count_q <= frame_count_q + 16'd1;
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_mandel_frame_reader.sv
// Directed bench for mandel_frame_reader (2 strips x 4 cols x 3 rows, read latency 2).
module tb_mandel_frame_reader;

    localparam int P = 2, C = 4, R = 3, RL = 2, NPIX = 24;

    logic       clk = 1'b0;
    logic       reset, start, iter_done, pix_ready;
    logic [3:0] addr;
    logic [0:0] part;
    logic [7:0] vga_data;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic [2:0] pix_x;
    logic [1:0] pix_y;
    logic       pix_last, busy, frame_done;
`ifdef MANDEL_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    always #5 clk = ~clk;

    mandel_frame_reader #(
        .PARTITION(P), .PARTITION_COLS(C), .PARTITION_ROWS(R), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .iter_done(iter_done),
        .m10k_read_address(addr), .partition_index(part), .vga_data(vga_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .busy(busy),
        .frame_done(frame_done)
`ifdef MANDEL_FRAME_COUNT_EN
        , .frame_count(frame_count)
`endif
    );

    // Memory model: {partition, addr[6:0]} returned two cycles after the address
    logic [7:0] mem_p1, mem_p2;
    always @(posedge clk) begin
        mem_p1 <= {part, 3'b000, addr};
        mem_p2 <= mem_p1;
    end
    assign vga_data = mem_p2;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] x;
        logic [1:0] y;
        logic       last;
    } pix_t;

    logic [7:0] exp_data [NPIX] = '{
        8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83,
        8'h04, 8'h05, 8'h06, 8'h07, 8'h84, 8'h85, 8'h86, 8'h87,
        8'h08, 8'h09, 8'h0A, 8'h0B, 8'h88, 8'h89, 8'h8A, 8'h8B};
    pix_t exp_tbl [NPIX];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    pix_t cap [$];
    int issued, acc_cnt, max_out, done_cnt, done_cyc, first_acc_cyc, last_acc_cyc;
    logic [4:0] prev_ap;
    logic [15:0] fc_seen;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int out;
        if (busy && ({part, addr} != prev_ap)) issued++;
        prev_ap = {part, addr};
        out = issued - acc_cnt;
        if (out > max_out) max_out = out;
        if (pix_valid && pix_ready) begin
            cap.push_back({pix_data, pix_x, pix_y, pix_last});
            if (acc_cnt == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            acc_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef MANDEL_FRAME_COUNT_EN
            fc_seen = frame_count;
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        cap.delete();
        issued = 0; acc_cnt = 0; max_out = 0; done_cnt = 0;
        done_cyc = 0; first_acc_cyc = 0; last_acc_cyc = 0;
        prev_ap = {part, addr};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input bit rnd);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            tick();
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("done_timeout", 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        chk("acc_timeout", 32'(acc_cnt >= target), 1);
    endtask

    task automatic check_stream(input string tag);
        pix_t a;
        chk({tag, "_len"}, cap.size(), NPIX);
        for (int k = 0; k < NPIX; k++) begin
            a = (k < cap.size()) ? cap[k] : '0;
            chk($sformatf("%s_pix%0d", tag, k), 32'(a), 32'(exp_tbl[k]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        clear_mon();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit   bad;
        pix_t snap;
        logic snap_v;

        for (int k = 0; k < NPIX; k++) begin
            exp_tbl[k].data = exp_data[k];
            exp_tbl[k].x    = 3'(k % 8);
            exp_tbl[k].y    = 2'(k / 8);
            exp_tbl[k].last = (k == NPIX - 1);
        end

        reset = 1'b1; start = 1'b0; iter_done = 1'b0; pix_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_addr", {part, addr}, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_pix", {pix_data, pix_x, pix_y, pix_last}, 0);
`ifdef MANDEL_FRAME_COUNT_EN
        chk("rst_fc", frame_count, 0);
`endif
        reset = 1'b0;
        clear_mon();

        // Full frame, ready held high, start at cycle 0 with iter_done already high
        iter_done = 1'b1; pix_ready = 1'b1;
        pulse_start();
        chk("s1_c1_busy", busy, 1);
        chk("s1_c1_addr", {part, addr}, 0);
        tick();
        chk("s1_c2_addr", {part, addr}, 0);
        chk("s1_c2_valid", pix_valid, 0);
        tick();
        chk("s1_c3_addr", {part, addr}, 1);
        tick();
        chk("s1_c4_valid", pix_valid, 0);
        tick();
        chk("s1_c5_valid", pix_valid, 1);
        chk("s1_c5_data", pix_data, 8'h00);
        wait_done(1, 1'b0);
        repeat (3) tick();
        chk("s1_done_once", done_cnt, 1);
        chk("s1_done_lat", done_cyc - last_acc_cyc, 1);
        chk("s1_no_bubble", last_acc_cyc - first_acc_cyc, NPIX - 1);
        chk("s1_idle", busy, 0);
        check_stream("s1");

        // start with iter_done low: hold, then fetch two cycles after it rises
        clear_mon();
        iter_done = 1'b0;
        pulse_start();
        bad = 1'b0;
        repeat (10) begin
            tick();
            if ({part, addr} != 5'd0 || busy !== 1'b1 || pix_valid !== 1'b0) bad = 1'b1;
        end
        chk("s2_hold", bad, 0);
        iter_done = 1'b1;
        tick();
        chk("s2_fetch_addr0", {part, addr}, 0);
        tick();
        chk("s2_fetch_addr1", {part, addr}, 1);
        iter_done = 1'b0;
        wait_done(1, 1'b0);
        check_stream("s2");

        // Consumer stall of 20 cycles mid-frame
        clear_mon();
        iter_done = 1'b1; pix_ready = 1'b1;
        pulse_start();
        wait_acc(8);
        pix_ready = 1'b0;
        tick();
        snap   = {pix_data, pix_x, pix_y, pix_last};
        snap_v = pix_valid;
        bad = 1'b0;
        repeat (19) begin
            tick();
            if (pix_valid !== snap_v || {pix_data, pix_x, pix_y, pix_last} !== snap) bad = 1'b1;
        end
        chk("s3_stall_valid", snap_v, 1);
        chk("s3_stall_hold", bad, 0);
        pix_ready = 1'b1;
        wait_done(1, 1'b0);
        check_stream("s3");
        chk("s3_max_out", max_out, 4);

        // Random backpressure
        clear_mon();
        pulse_start();
        wait_done(1, 1'b1);
        pix_ready = 1'b1;
        check_stream("s4");
        chk("s4_max_out_le4", 32'(max_out <= 4), 1);

        // Reset mid-frame at pixel 10, then a clean frame
        clear_mon();
        pulse_start();
        wait_acc(10);
        reset = 1'b1;
        #1;
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_valid", pix_valid, 0);
        chk("s5_rst_addr", {part, addr}, 0);
        repeat (2) tick();
        reset = 1'b0;
        clear_mon();
        pulse_start();
        wait_done(1, 1'b0);
        repeat (3) tick();
        check_stream("s5");

`ifdef MANDEL_FRAME_COUNT_EN
        do_reset();
        chk("s6_fc_rst", frame_count, 0);
        for (int f = 1; f <= 3; f++) begin
            pulse_start();
            wait_done(f, 1'b0);
            chk($sformatf("s6_fc%0d", f), fc_seen, f);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mandel_frame_reader.md
# mandel_frame_reader

Raster-order framebuffer reader that sits directly downstream of the partitioned Mandelbrot iterator array. Once the iterators report completion, it walks every screen pixel in row-major order and drives the array's shared M10K read address and partition select. It absorbs the fixed memory read latency and streams one 8-bit colour byte per pixel to the VGA writer over a valid/ready handshake. It needs no multiplier: all addresses come from incremental counters.

## Interface
Parameters:
- PARTITION, 2: number of vertical column strips; one iterator/M10K per strip.
- PARTITION_COLS, 320: screen columns per strip.
- PARTITION_ROWS, 480: screen rows, identical for all strips.
- READ_LATENCY, 2: cycles from address/partition presented to valid `vga_data`; must be at least 1.

Derived values:
- W = PARTITION*PARTITION_COLS
- AW = $clog2(PARTITION_COLS*PARTITION_ROWS)
- DEPTH = READ_LATENCY+2

Ports:
- clk  in  1  system clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to read out a frame.
- iter_done  in  1  high when all iterators have finished.
- m10k_read_address  out  AW  word address within a strip.
- partition_index  out  $clog2(PARTITION)  strip select.
- vga_data  in  8  colour byte returned READ_LATENCY cycles after address.
- pix_valid  out  1  output byte available.
- pix_ready  in  1  consumer accepts when pix_valid && pix_ready.
- pix_data  out  8  colour byte.
- pix_x  out  $clog2(W)  screen column of pix_data.
- pix_y  out  $clog2(PARTITION_ROWS)  screen row of pix_data.
- pix_last  out  1  pix_data is pixel (W-1, PARTITION_ROWS-1).
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

## Operation
- States are IDLE, WAIT_DONE, FETCH and DRAIN.
- IDLE → WAIT_DONE on start. start is ignored in every other state.
- WAIT_DONE → FETCH in the first cycle iter_done is sampled high. iter_done is not examined after this point; a fall during FETCH has no effect.
- FETCH issues reads in raster order: for y in 0..ROWS-1, for p in 0..PARTITION-1, for c in 0..COLS-1.
  - Read address is row_base+c.
  - row_base advances by PARTITION_COLS when the row wraps, and returns to 0 at frame end.
- A read is issued in a cycle only if fifo_count + in_flight < DEPTH. Otherwise the address/partition hold, and no read is counted.
- A valid-bit shift register of length READ_LATENCY tags each issued read. The tagged `vga_data` byte is pushed into a DEPTH-entry FIFO, together with the x/y/last of that read.
- After issuing the final read: FETCH → DRAIN.
- DRAIN → IDLE on the cycle the pix_last byte is accepted. frame_done pulses in the following cycle.
- pix_valid = FIFO not empty. pix_data/pix_x/pix_y/pix_last come from the FIFO head.
- A FIFO push and pop in the same cycle keep the count unchanged. Overflow is impossible by the credit rule.

## Timing
- Reset values: every output 0; state IDLE; FIFO empty; in_flight 0.
- start at cycle 0 with iter_done already high:
  - WAIT_DONE at cycle 1, FETCH at cycle 2.
  - First address (0, partition 0) is driven at cycle 2.
  - pix_valid rises at cycle 2+READ_LATENCY+1 (FIFO write, then read).
- Steady state with pix_ready held high: one pixel per cycle, no bubbles.
- pix_ready low: at most DEPTH reads are outstanding or buffered. Issue resumes the cycle after the first pop.
- Outputs are held stable while pix_valid && !pix_ready.
- Reset mid-frame: all in-flight reads are discarded, and the next start begins at pixel (0,0).

## Configuration
- MANDEL_FRAME_COUNT_EN defined:
  - Adds output port frame_count [15:0], reset to 0.
  - frame_count increments in the same cycle frame_done pulses and wraps from 65535 to 0.
- MANDEL_FRAME_COUNT_EN undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
All scenarios use PARTITION=2, COLS=4, ROWS=3, READ_LATENCY=2, with a memory model returning {partition, addr[6:0]}.
- Full frame, pix_ready=1: the 24 bytes arrive in order. Row 0 is p0 a0–3, then p1 a0–3; row 1 is p0 a4–7, then p1 a4–7. pix_last is only on byte 24, at x=7, y=2. frame_done pulses one cycle after.
- start with iter_done=0 for 10 cycles: no address activity and busy=1. Address 0 appears 2 cycles after iter_done rises.
- pix_ready low for 20 cycles mid-frame: the pixel sequence has no losses or duplicates. Never more than 4 reads are outstanding or buffered.
- Random pix_ready (50%): the output sequence is identical to the first scenario.
- Reset asserted at pixel 10, then start: the stream restarts at (0,0). No stale bytes appear.
- MANDEL_FRAME_COUNT_EN defined, three back-to-back frames: frame_count reads 1, 2, 3.
